// File: rtl/ram_stream_reader_pkg.sv
// Shared types and elaboration helpers for the RAM stream reader.
package ram_stream_reader_pkg;

   // Controller states: waiting for a request, issuing reads, emptying the pipeline.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Ceiling log2 with a floor of 1, so a width derived from it is never zero.
   function automatic int f_log2(input int value);
      int result;
      longint span;
      result = 0;
      span   = 1;
      while (span < longint'(value)) begin
         span   = span * 2;
         result = result + 1;
      end
      if (result < 1) begin
         result = 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/ram_stream_reader_fifo2_skid.sv
// Two-entry register FIFO that absorbs the RAM read latency under back-pressure.
module fifo2_skid
   import ram_stream_reader_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clock,
   input  logic             n_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic [1:0]       o_occ
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_occ;
   logic             w_pop_ok;
   logic             w_push_ok;

   // A pop needs a stored word; a push into a full FIFO only succeeds alongside a pop.
   assign w_pop_ok  = i_pop && (r_occ != 2'd0);
   assign w_push_ok = i_push && ((r_occ != 2'd2) || w_pop_ok);

   assign o_data = r_mem[r_rd_ptr];
   assign o_occ  = r_occ;

   // Storage, pointers and fill level.
   always_ff @(posedge clock or negedge n_rst) begin
      if (!n_rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_occ    <= 2'd0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase
      end
   end

endmodule

// File: rtl/ram_stream_reader.sv
// Read-side controller for a registered-read dual-port RAM: walks an address range
// (wrapping at RAM_SIZE) and streams the words out over valid/ready.
module ram_stream_reader
   import ram_stream_reader_pkg::*;
#(
   parameter  int WORD_SIZE = -1,
   parameter  int RAM_SIZE  = -1,
   localparam int ADDR_BITW = f_log2(RAM_SIZE),
   localparam int LEN_BITW  = f_log2(RAM_SIZE + 1)
) (
   input  logic                 clock,
   input  logic                 n_rst,
   input  logic                 start,
   input  logic [ADDR_BITW-1:0] start_addr,
   input  logic [LEN_BITW-1:0]  length,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_BITW-1:0] rd_addr,
   input  logic [WORD_SIZE-1:0] rd_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_SIZE-1:0] out_data,
   output logic                 out_last
);

   localparam logic [ADDR_BITW-1:0] LAST_ADDR = ADDR_BITW'(RAM_SIZE - 1);

   state_t                r_state;
   state_t                w_state_next;
   logic [ADDR_BITW-1:0]  r_rd_addr;
   logic [ADDR_BITW-1:0]  w_addr_next;
   logic [LEN_BITW-1:0]   r_issue_cnt;
   logic [LEN_BITW-1:0]   r_emit_cnt;
   logic                  r_inflight;
   logic                  r_inflight_last;
   logic                  r_done;
   logic                  w_accept;
   logic                  w_empty_req;
   logic                  w_issue;
   logic                  w_issue_room;
   logic                  w_final;
   logic                  w_pop;
   logic [1:0]            w_occ;
   logic [WORD_SIZE:0]    w_head;

   // "Issuing" a read means the RAM samples the current rd_addr at this edge; rd_addr
   // is pre-loaded with the first address on accept and advanced only when a read is
   // actually taken, so its data lands in the FIFO exactly one edge later.
   fifo2_skid #(
      .WIDTH (WORD_SIZE + 1)
   ) u_fifo (
      .clock  (clock),
      .n_rst  (n_rst),
      .i_push (r_inflight),
      .i_data ({r_inflight_last, rd_data}),
      .i_pop  (w_pop),
      .o_data (w_head),
      .o_occ  (w_occ)
   );

   assign out_valid = (w_occ != 2'd0);
   assign out_data  = w_head[WORD_SIZE-1:0];
   assign out_last  = w_head[WORD_SIZE] & out_valid;
   assign w_pop     = out_valid & out_ready;
   assign busy      = (r_state != ST_IDLE);
   assign done      = r_done;
   assign rd_addr   = r_rd_addr;

   // Buffered plus in-flight words, less this cycle's pop, must leave room for one more.
   assign w_issue_room = ({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});

   assign w_addr_next = (r_rd_addr == LAST_ADDR) ? '0 : r_rd_addr + ADDR_BITW'(1);

   // State register.
   always_ff @(posedge clock or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and per-cycle control decisions.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_empty_req  = 1'b0;
      w_issue      = 1'b0;
      w_final      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (length != '0) begin
                  w_accept     = 1'b1;
                  w_state_next = ST_READ;
               end else begin
                  w_empty_req = 1'b1;
               end
            end
         end
         ST_READ: begin
            if (r_issue_cnt == '0) begin
               w_state_next = ST_DRAIN;
            end else if (w_issue_room) begin
               w_issue = 1'b1;
               if (r_issue_cnt == LEN_BITW'(1)) begin
                  w_state_next = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (w_pop && (r_emit_cnt == LEN_BITW'(1))) begin
               w_final      = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Address, counters, in-flight tracking and the done pulse.
   always_ff @(posedge clock or negedge n_rst) begin
      if (!n_rst) begin
         r_rd_addr       <= '0;
         r_issue_cnt     <= '0;
         r_emit_cnt      <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_done          <= 1'b0;
      end else begin
         r_done          <= w_final | w_empty_req;
         r_inflight      <= w_issue;
         r_inflight_last <= w_issue && (r_issue_cnt == LEN_BITW'(1));
         if (w_accept) begin
            r_rd_addr   <= start_addr;
            r_issue_cnt <= length;
            r_emit_cnt  <= length;
         end else begin
            if (w_issue) begin
               r_issue_cnt <= r_issue_cnt - LEN_BITW'(1);
               if (r_issue_cnt != LEN_BITW'(1)) begin
                  r_rd_addr <= w_addr_next;
               end
            end
            if (w_pop && (r_emit_cnt != '0)) begin
               r_emit_cnt <= r_emit_cnt - LEN_BITW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader with a behavioural registered-read RAM holding mem[i]=i+0x10.
module tb_ram_stream_reader;

   localparam int WS = 8;
   localparam int RS = 12;
   localparam int AW = 4;
   localparam int LW = 4;

   logic          clock = 1'b0;
   logic          n_rst = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [LW-1:0] length = '0;
   logic          busy;
   logic          done;
   logic [AW-1:0] rd_addr;
   logic [WS-1:0] rd_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [WS-1:0] out_data;
   logic          out_last;

   logic [WS-1:0] mem [RS];

   int errors = 0;
   int checks = 0;
   int cur_id = 0;

   typedef struct {
      int addr;
      int len;
      int mode;       // 0: ready high, 1: random ready, 2: low on cycles 3..6 then random
      bit poke;       // pulse start again while busy
      int exp_first;  // -1: not checked
      int exp_final;
      int exp_done;   // cycle of done pulse after start, -1: not checked
   } vec_t;

   vec_t vecs[$];

   always #5 clock = ~clock;

   initial begin
      for (int i = 0; i < RS; i++) mem[i] = WS'(i + 16);
   end

   always @(posedge clock) begin
      rd_data <= (int'(rd_addr) < RS) ? mem[rd_addr] : 8'hEE;
   end

   ram_stream_reader #(
      .WORD_SIZE (WS),
      .RAM_SIZE  (RS)
   ) dut (
      .clock      (clock),
      .n_rst      (n_rst),
      .start      (start),
      .start_addr (start_addr),
      .length     (length),
      .busy       (busy),
      .done       (done),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL xfer%0d %s: got 0x%0h expected 0x%0h", cur_id, name, act, exp);
      end
   endtask

   // Reference word k of a transfer: plain modular walk over the preload pattern.
   function automatic int ref_word(input int addr, input int k);
      return 16 + ((addr + k) % RS);
   endfunction

   // Caller is positioned just after a negedge; start is driven immediately.
   task automatic run_xfer(input vec_t v);
      int            n = 0;
      int            words = 0;
      int            adv = 0;
      int            last_hs = -1;
      bit            fin = 0;
      bit            first_seen = 0;
      logic          prev_valid = 0;
      logic          prev_ready = 0;
      logic          prev_last = 0;
      logic          prev_busy = 0;
      logic [WS-1:0] prev_data = '0;
      logic [AW-1:0] prev_addr;
      logic          rdy;
      prev_addr  = rd_addr;
      start      = 1'b1;
      start_addr = AW'(v.addr);
      length     = LW'(v.len);
      out_ready  = 1'b1;
      while (!fin) begin
         @(negedge clock);
         n++;
         start = 1'b0;
         if (v.poke && n == 3) begin
            start      = 1'b1;
            start_addr = AW'(0);
            length     = LW'(5);
         end
         if (n > 200) begin
            chk("timeout_waiting_done", n, 200);
            break;
         end
         if (prev_valid && !prev_ready) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, prev_data);
            chk("hold_last", out_last, prev_last);
         end
         if (prev_busy && busy && rd_addr != prev_addr) adv++;
         chk("reads_ahead_le2", int'((adv - words) <= 2), 1);
         if (done) begin
            fin = 1;
            chk("words_at_done", words, v.len);
            chk("done_after_last_hs", n, (v.len == 0) ? 1 : last_hs + 1);
            if (v.exp_done >= 0) chk("done_cycle", n, v.exp_done);
            chk("busy_at_done", busy, 0);
            chk("valid_at_done", out_valid, 0);
         end else begin
            if (v.len != 0) chk("busy_during", busy, 1);
            case (v.mode)
               0:       rdy = 1'b1;
               1:       rdy = ($urandom_range(0, 3) != 0);
               default: rdy = (n >= 3 && n <= 6) ? 1'b0 : 1'(($urandom_range(0, 1)));
            endcase
            out_ready = rdy;
            if (out_valid) begin
               chk("valid_only_when_owed", int'(words < v.len), 1);
               if (!first_seen) begin
                  first_seen = 1;
                  if (v.mode == 0) chk("first_valid_cycle", n, 3);
               end
               if (rdy) begin
                  chk($sformatf("data_w%0d", words), out_data, ref_word(v.addr, words));
                  chk($sformatf("last_w%0d", words), out_last, int'(words == v.len - 1));
                  if (words == 0 && v.exp_first >= 0) chk("first_word", out_data, v.exp_first);
                  if (words == v.len - 1 && v.exp_final >= 0) chk("final_word", out_data, v.exp_final);
                  words++;
                  last_hs = n;
               end
            end
         end
         prev_valid = out_valid;
         prev_ready = out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
         prev_busy  = busy;
         prev_addr  = rd_addr;
      end
      out_ready = 1'b1;
      @(negedge clock);
      chk("done_one_cycle", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_valid", out_valid, 0);
   endtask

   initial begin
      vec_t v;
      int   seen;
      int   n;

      vecs.push_back('{addr: 2,  len: 4,  mode: 0, poke: 0, exp_first: 'h12, exp_final: 'h15, exp_done: 7});
      vecs.push_back('{addr: 10, len: 4,  mode: 0, poke: 0, exp_first: 'h1A, exp_final: 'h11, exp_done: 7});
      vecs.push_back('{addr: 0,  len: 12, mode: 0, poke: 0, exp_first: 'h10, exp_final: 'h1B, exp_done: 15});
      vecs.push_back('{addr: 2,  len: 4,  mode: 2, poke: 0, exp_first: 'h12, exp_final: 'h15, exp_done: -1});
      vecs.push_back('{addr: 5,  len: 0,  mode: 0, poke: 0, exp_first: -1,   exp_final: -1,   exp_done: 1});
      vecs.push_back('{addr: 2,  len: 4,  mode: 0, poke: 1, exp_first: 'h12, exp_final: 'h15, exp_done: 7});
      vecs.push_back('{addr: 11, len: 1,  mode: 0, poke: 0, exp_first: 'h1B, exp_final: 'h1B, exp_done: 4});
      vecs.push_back('{addr: 7,  len: 12, mode: 1, poke: 0, exp_first: 'h17, exp_final: 'h16, exp_done: -1});

      // Reset values, checked asynchronously before any clock edge.
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      @(negedge clock);
      @(negedge clock);
      n_rst = 1'b1;
      @(negedge clock);

      foreach (vecs[i]) begin
         cur_id = i;
         run_xfer(vecs[i]);
      end

      // Reset in the middle of a transfer after two words have been consumed.
      cur_id = 100;
      start = 1'b1; start_addr = AW'(2); length = LW'(6); out_ready = 1'b1;
      seen = 0;
      n = 0;
      while (seen < 2 && n < 50) begin
         @(negedge clock);
         n++;
         start = 1'b0;
         if (out_valid && out_ready) begin
            chk("pre_reset_word", out_data, ref_word(2, seen));
            seen++;
         end
      end
      chk("pre_reset_words_seen", seen, 2);
      @(posedge clock);
      #2 n_rst = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_rd_addr", rd_addr, 0);
      chk("abort_valid", out_valid, 0);
      chk("abort_last", out_last, 0);
      chk("abort_data", out_data, 0);
      @(negedge clock);
      @(negedge clock);
      n_rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         chk("post_abort_no_done", done, 0);
         chk("post_abort_no_valid", out_valid, 0);
      end
      cur_id = 101;
      run_xfer('{addr: 2, len: 6, mode: 0, poke: 0, exp_first: 'h12, exp_final: 'h17, exp_done: 9});

      // Randomised transfers, back to back.
      for (int r = 0; r < 24; r++) begin
         cur_id    = 200 + r;
         v.addr    = int'($urandom_range(0, RS - 1));
         v.len     = int'($urandom_range(0, RS));
         v.mode    = int'($urandom_range(0, 2));
         v.poke    = 1'($urandom_range(0, 1));
         v.exp_first = -1;
         v.exp_final = -1;
         v.exp_done  = (v.mode == 0) ? ((v.len == 0) ? 1 : v.len + 3) : -1;
         run_xfer(v);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
